uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Oversampling UART/UPDI receiver and the parametrised successor to the simple bit-per-clock RX.
- Synchronises the asynchronous rx line and detects the start-bit edge.
- Samples each bit at mid-bit using a CLKS_PER_BIT counter.
- Checks parity and every stop bit, and reports data, parity errors and framing errors as separate one-cycle pulses.
- Sits between the UPDI pin interface and the UPDI protocol engine. Defaults match UPDI framing: 8 data bits, even parity, 2 stop bits.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5-9, LSB first.
PARITY_BIT, "even", one of "none", "even", "odd".
STOP_BITS, 2, stop bits checked per frame, legal range 1-2.
CLKS_PER_BIT, 16, clk cycles per bit period, minimum 4; HALF = CLKS_PER_BIT/2 (integer division).
SYNC_STAGES, 2, rx synchroniser depth, minimum 2.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
rx  input  1  asynchronous serial line, idle high.
rx_data  output  DATA_BITS  last good received word; updates only when rx_data_valid is asserted.
rx_data_valid  output  1  one-cycle pulse: frame received with good parity and good stop bits.
rx_parity_error  output  1  one-cycle pulse: parity mismatch.
rx_frame_error  output  1  one-cycle pulse: a stop bit was sampled low.
rx_break  output  1  one-cycle pulse on break; tied 0 unless the optional feature is compiled in.
rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, synchroniser flops 1, state IDLE, counters 0. Reset mid-frame abandons the frame with no pulses.
- rx_s is rx after SYNC_STAGES flops. All decisions use rx_s only.
- States: IDLE, START, DATA, PARITY (skipped if "none"), STOP, WAIT_HIGH.
- IDLE: on the first cycle with rx_s==0 (call it t0), go to START with the bit counter cleared.
- Bit k of the frame (k=0 is the start bit) is sampled at cycle t0+HALF+k*CLKS_PER_BIT.
- START: if the start sample is 1, it is a false start; return to IDLE with no pulses. Otherwise go to DATA.
- DATA: shift in DATA_BITS samples, LSB first, then go to PARITY or STOP.
- PARITY: store the sample. Expected parity is the XOR of the data bits for "even", and its inverse for "odd".
- STOP: sample STOP_BITS bits; any 0 sample flags a framing error.
- Result pulses are asserted on the cycle after the last stop sample:
  - Valid is asserted only with no error, and rx_data updates in the same cycle.
  - parity_error and frame_error may pulse together.
  - On any error, rx_data holds its previous value.
- After a good last stop sample, go to IDLE immediately (mid stop bit), so back-to-back frames are accepted.
- After a framing error, go to WAIT_HIGH and stay until rx_s==1, then go to IDLE. This prevents a held-low line from retriggering a frame.
- rx_busy is 0 in IDLE and 1 in all other states, including WAIT_HIGH.
- Counters are sized with $clog2 of CLKS_PER_BIT and of the frame bit count. No wrap-around occurs within a frame.

Optional Feature:
Macro: UART_RX_BREAK_DETECT_EN.
- Defined: a frame whose start, data, parity (if present) and all stop samples are 0 is a break.
  - Pulse rx_break once; do not pulse rx_frame_error or rx_parity_error.
  - Then go to WAIT_HIGH.
  - A line held low for any duration yields exactly one rx_break.
- Undefined: rx_break is constant 0 and an all-zero frame is reported as an ordinary framing error (plus a parity error if applicable).

Test Plan:
1. Defaults (CPB=16, 8E2). Send 0x5A with parity 0 and stop 1,1 -> rx_data_valid pulses once at t0+8+11*16+1, rx_data=0x5A, no error pulses.
2. Send 0x5A with parity bit 1 -> rx_parity_error pulses once, rx_data_valid stays 0, rx_data stays 0x5A.
3. Send 0x33 with first stop bit 0, then hold rx low 3 bit times, then release high -> one rx_frame_error, no new frame while low, rx_busy=1 until rx_s returns to 1.
4. Pulse rx low for 4 clk and return high -> no output pulses; rx_busy returns to 0 after the start sample at t0+8.
5. Hold rx low for 20 bit times -> with UART_RX_BREAK_DETECT_EN: exactly one rx_break and no error pulses. Without the macro: one rx_frame_error, rx_break=0.
6. Two back-to-back frames 0xA5, 0x0F with no idle gap, then assert rst during a third frame's DATA state -> two valid pulses with correct data; after rst all outputs are 0 and no pulse occurs for the aborted frame.

Source files
------------

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART/UPDI receiver (default framing 8E2).
// Synchronises rx, samples each bit at mid-bit, and reports data, parity
// error, framing error and (optionally) break as one-cycle pulses.
// Optional feature macro: UART_RX_BREAK_DETECT_EN (break detection; when
// undefined rx_break is tied 0 and an all-zero frame is a framing error).
module uart_rx_os #(
  parameter int unsigned DATA_BITS    = 8,
  parameter string       PARITY_BIT   = "even",
  parameter int unsigned STOP_BITS    = 2,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_parity_error,
  output logic                 rx_frame_error,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam logic        HAS_PAR    = (PARITY_BIT != "none");
  localparam logic        ODD        = (PARITY_BIT == "odd");
  localparam int unsigned FRAME_BITS = 1 + DATA_BITS + (HAS_PAR ? 1 : 0) + STOP_BITS;
  localparam int unsigned CW         = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW         = $clog2(FRAME_BITS);

  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_clk;
  logic [BW-1:0]          r_bit;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_par;
  logic                   r_ferr;
  logic                   r_valid;
  logic                   r_perr;
  logic                   r_ferr_p;
  logic                   r_break;

  logic w_rx_s;
  logic w_sample;
  logic w_ferr;
  logic w_perr;
  logic w_brk;

  assign w_rx_s = r_sync[SYNC_STAGES-1];
  assign w_ferr = r_ferr | ~w_rx_s;
  assign w_perr = HAS_PAR & (r_par != ((^r_shift) ^ ODD));

  // Synchronise the asynchronous rx line; idles high.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
  end

  // Sample strobe: half a bit after the start edge, then every full bit.
  always_comb begin
    w_sample = 1'b0;
    case (r_state)
      START:             w_sample = (r_clk == HALF_LAST);
      DATA, PARITY, STOP: w_sample = (r_clk == CLK_LAST);
      default:           w_sample = 1'b0;
    endcase
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_zero;

  // Track whether every sample of the current frame so far has been 0.
  always_ff @(posedge clk) begin
    if (rst || r_state == IDLE) r_zero <= 1'b1;
    else if (w_sample)          r_zero <= r_zero & ~w_rx_s;
  end

  assign w_brk = r_zero & ~w_rx_s;
`else
  assign w_brk = 1'b0;
`endif

  // Frame FSM with registered result pulses; results are decided at the
  // last stop sample so the pulses appear on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_clk    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_par    <= 1'b0;
      r_ferr   <= 1'b0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr_p <= 1'b0;
      r_break  <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr_p <= 1'b0;
      r_break  <= 1'b0;
      if (r_state inside {START, DATA, PARITY, STOP})
        r_clk <= w_sample ? '0 : r_clk + 1'b1;
      else
        r_clk <= '0;
      case (r_state)
        IDLE: begin
          r_bit  <= '0;
          r_ferr <= 1'b0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (w_sample) r_state <= w_rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit == DATA_LAST) begin
              r_bit   <= '0;
              r_state <= HAS_PAR ? PARITY : STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_sample) begin
            r_par   <= w_rx_s;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_sample) begin
            if (r_bit != STOP_LAST) begin
              r_ferr <= w_ferr;
              r_bit  <= r_bit + 1'b1;
            end else if (w_brk) begin
              r_break <= 1'b1;
              r_state <= WAIT_HIGH;
            end else begin
              r_ferr_p <= w_ferr;
              r_perr   <= w_perr;
              if (!w_ferr && !w_perr) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
              end
              r_state <= w_ferr ? WAIT_HIGH : IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data         = r_data;
  assign rx_data_valid   = r_valid;
  assign rx_parity_error = r_perr;
  assign rx_frame_error  = r_ferr_p;
  assign rx_break        = r_break;
  assign rx_busy         = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Testbench for uart_rx_os at default parameters (CPB=16, 8E2, 2 sync stages).
module tb_uart_rx_os;

  localparam int CPB = 16;
  // start-drive negedge -> valid pulse: 2 sync + 1 detect + HALF + 11*CPB
  localparam int VALID_LAT = 3 + 8 + 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_parity_error, rx_frame_error, rx_break, rx_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int n_valid = 0, n_perr = 0, n_ferr = 0, n_brk = 0, last_valid_cyc = 0;
  logic [7:0] vq[$];
  int b_valid, b_perr, b_ferr, b_brk;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s1;
    logic       s2;
    int         ev;
    int         ep;
    int         ef;
    logic [7:0] edata;
  } vec_t;

  vec_t tbl[9];

  uart_rx_os dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .rx_break        (rx_break),
    .rx_busy         (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_data_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      vq.push_back(rx_data);
    end
    if (rx_parity_error) n_perr++;
    if (rx_frame_error)  n_ferr++;
    if (rx_break)        n_brk++;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_perr  = n_perr;
    b_ferr  = n_ferr;
    b_brk   = n_brk;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, output int t_start);
    t_start = cyc;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    int t0, t1, qb;

    //            data   par   s1    s2   v  p  f  data after
    tbl[0] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h5A};
    tbl[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 0, 1, 0, 8'h5A};
    tbl[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'h00};
    tbl[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'hFF};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1, 0, 0, 8'h01};
    tbl[5] = '{8'h01, 1'b0, 1'b1, 1'b1, 0, 1, 0, 8'h01};
    tbl[6] = '{8'h33, 1'b0, 1'b0, 1'b1, 0, 0, 1, 8'h01};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b0, 0, 1, 1, 8'h01};
    tbl[8] = '{8'hC3, 1'b0, 1'b1, 1'b1, 1, 0, 0, 8'hC3};

    // reset state
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data",  int'(rx_data), 0);
    chk("rst_valid", int'(rx_data_valid), 0);
    chk("rst_perr",  int'(rx_parity_error), 0);
    chk("rst_ferr",  int'(rx_frame_error), 0);
    chk("rst_brk",   int'(rx_break), 0);
    chk("rst_busy",  int'(rx_busy), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // table-driven frames
    for (int i = 0; i < 9; i++) begin
      snap();
      send_bits({4'b0, tbl[i].s2, tbl[i].s1, tbl[i].p, tbl[i].d, 1'b0}, 12, t0);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      chk($sformatf("v%0d_valid", i), n_valid - b_valid, tbl[i].ev);
      chk($sformatf("v%0d_perr", i),  n_perr - b_perr,   tbl[i].ep);
      chk($sformatf("v%0d_ferr", i),  n_ferr - b_ferr,   tbl[i].ef);
      chk($sformatf("v%0d_brk", i),   n_brk - b_brk,     0);
      chk($sformatf("v%0d_data", i),  int'(rx_data),     int'(tbl[i].edata));
      chk($sformatf("v%0d_busy", i),  int'(rx_busy),     0);
      if (tbl[i].ev == 1)
        chk($sformatf("v%0d_latency", i), last_valid_cyc - t0, VALID_LAT);
    end

    // first stop bit low, then line held low for 3 more bit times
    snap();
    send_bits({5'b0, 1'b0, 1'b0, 8'h33, 1'b0}, 11, t0);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk("hold_busy",  int'(rx_busy), 1);
    chk("hold_ferr",  n_ferr - b_ferr, 1);
    chk("hold_valid", n_valid - b_valid, 0);
    chk("hold_perr",  n_perr - b_perr, 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("hold_busy_release", int'(rx_busy), 0);
    repeat (2 * CPB) @(negedge clk);
    chk("hold_no_new_frame", n_valid - b_valid, 0);
    chk("hold_ferr_once",    n_ferr - b_ferr, 1);
    chk("hold_data_kept",    int'(rx_data), 8'hC3);

    // false start: 4 clk low glitch
    snap();
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_start", int'(rx_busy), 1);
    repeat (8) @(negedge clk);
    chk("glitch_busy_idle", int'(rx_busy), 0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_pulses", (n_valid - b_valid) + (n_perr - b_perr) + (n_ferr - b_ferr) + (n_brk - b_brk), 0);

    // line held low for 20 bit times
    snap();
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    chk("low20_busy", int'(rx_busy), 1);
`ifdef UART_RX_BREAK_DETECT_EN
    chk("low20_brk",  n_brk - b_brk, 1);
    chk("low20_ferr", n_ferr - b_ferr, 0);
`else
    chk("low20_brk",  n_brk - b_brk, 0);
    chk("low20_ferr", n_ferr - b_ferr, 1);
`endif
    chk("low20_perr",  n_perr - b_perr, 0);
    chk("low20_valid", n_valid - b_valid, 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("low20_busy_release", int'(rx_busy), 0);
    chk("low20_data_kept",    int'(rx_data), 8'hC3);

    // back-to-back frames, then reset during a third frame
    snap();
    qb = vq.size();
    send_bits({4'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0}, 12, t0);
    send_bits({4'b0, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0}, 12, t1);
    chk("b2b_count", n_valid - b_valid, 2);
    chk("b2b_latency", last_valid_cyc - t1, VALID_LAT);
    if (vq.size() >= qb + 2) begin
      chk("b2b_data0", int'(vq[qb]), 8'hA5);
      chk("b2b_data1", int'(vq[qb + 1]), 8'h0F);
    end else begin
      chk("b2b_queue", vq.size() - qb, 2);
    end
    chk("b2b_rx_data", int'(rx_data), 8'h0F);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    chk("f3_busy_pre_rst", int'(rx_busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("f3_rst_data",  int'(rx_data), 0);
    chk("f3_rst_valid", int'(rx_data_valid), 0);
    chk("f3_rst_perr",  int'(rx_parity_error), 0);
    chk("f3_rst_ferr",  int'(rx_frame_error), 0);
    chk("f3_rst_brk",   int'(rx_break), 0);
    chk("f3_rst_busy",  int'(rx_busy), 0);
    rst = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    chk("f3_valid", n_valid - b_valid, 2);
    chk("f3_errs", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_brk - b_brk), 0);
    chk("f3_data",  int'(rx_data), 0);
    chk("f3_busy",  int'(rx_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
